btn_event_decoder: RTL and testbench

Converts the clean, debounced level of one physical alarm-panel button into single-cycle key events for the alarm control logic:
- a short press on release;
- a long press once a hold threshold is reached;
- periodic auto-repeat pulses while the long hold continues.

One instance sits behind each debounced button. Its outputs go directly to the time-set and alarm-arm state machines.

---
 rtl/btn_event_decoder.sv | 95 +++++++++
 tb/tb_btn_event_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// Turns one debounced button level into short-press, long-press and auto-repeat
// single-cycle events. All outputs are registered; state is exposed as a struct-free enum.
module btn_event_decoder #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 25_000_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 27
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_held,
  output logic o_press,
  output logic o_long,
  output logic o_repeat
);

  typedef enum logic [1:0] {
    S_WAIT_REL = 2'd0,
    S_IDLE     = 2'd1,
    S_SHORT    = 2'd2,
    S_LONG     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_held;
  logic             r_press;
  logic             r_long;
  logic             r_repeat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_WAIT_REL;
      r_cnt    <= '0;
      r_held   <= 1'b0;
      r_press  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      // Event outputs are pulses: cleared every cycle unless set below.
      r_press  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      case (r_state)
        S_WAIT_REL: begin
          // A button held through reset must be released before it counts.
          if (!i_btn) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (i_btn) begin
            r_state <= S_SHORT;
            r_cnt   <= CNT_ONE;
            r_held  <= 1'b1;
          end
        end
        S_SHORT: begin
          if (!i_btn) begin
            r_state <= S_IDLE;
            r_press <= 1'b1;
            r_held  <= 1'b0;
          end else if (r_cnt == LONG_MAX) begin
            r_state <= S_LONG;
            r_long  <= 1'b1;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_LONG: begin
          if (!i_btn) begin
            r_state <= S_IDLE;
            r_held  <= 1'b0;
          end else if (r_cnt == REPEAT_MAX) begin
            r_repeat <= REPEAT_EN;
            r_cnt    <= CNT_ONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= S_WAIT_REL;
      endcase
    end
  end

  assign o_held   = r_held;
  assign o_press  = r_press;
  assign o_long   = r_long;
  assign o_repeat = r_repeat;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with LONG_CYCLES=10, REPEAT_CYCLES=4:
// a table of per-edge {rst, btn, expected outputs} plus a reset-during-pulse sequence.
module tb_btn_event_decoder;

  logic clk;
  logic rst;
  logic btn;
  logic held;
  logic press;
  logic long_p;
  logic rep;

  int n_checks;
  int n_errors;

  // exp = {held, press, long, repeat} observed just after the edge.
  typedef struct packed {
    logic       rst;
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  btn_event_decoder #(
    .LONG_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .REPEAT_EN    (1'b1),
    .CNT_W        (8)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_btn   (btn),
    .o_held  (held),
    .o_press (press),
    .o_long  (long_p),
    .o_repeat(rep)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got held/press/long/rep=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: set inputs, take one edge, sample #1 later.
  task automatic step(input logic r, input logic b);
    rst = r;
    btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic r, input logic b, input logic [3:0] e);
    vec_t v;
    v.rst = r;
    v.btn = b;
    v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  localparam logic [3:0] Z = 4'b0000;
  localparam logic [3:0] H = 4'b1000;
  localparam logic [3:0] P = 4'b0100;
  localparam logic [3:0] HL = 4'b1010;
  localparam logic [3:0] HR = 4'b1001;

  initial begin
    int edges;
    bit seen;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    btn = 1'b0;

    // 1. reset then short press E0..E2, release E3
    add(1, 1, 0, Z);
    add(1, 0, 0, Z);
    add(3, 0, 1, H);
    add(1, 0, 0, P);
    add(1, 0, 0, Z);
    // 2. long hold E0..E20, release E21
    add(10, 0, 1, H);
    add(1, 0, 1, HL);
    add(3, 0, 1, H);
    add(1, 0, 1, HR);
    add(3, 0, 1, H);
    add(1, 0, 1, HR);
    add(2, 0, 1, H);
    add(1, 0, 0, Z);
    add(1, 0, 0, Z);
    // 3. release exactly at E10 is a short press
    add(10, 0, 1, H);
    add(1, 0, 0, P);
    add(1, 0, 0, Z);
    // 4. stuck button across reset
    add(1, 1, 1, Z);
    add(30, 0, 1, Z);
    add(1, 0, 0, Z);
    add(2, 0, 1, H);
    add(1, 0, 0, P);
    add(1, 0, 0, Z);
    // 5. reset at E12 during long hold, release later gives nothing
    add(10, 0, 1, H);
    add(1, 0, 1, HL);
    add(1, 0, 1, H);
    add(1, 1, 1, Z);
    add(5, 0, 1, Z);
    add(2, 0, 0, Z);
    // 6. back-to-back presses
    add(3, 0, 1, H);
    add(1, 0, 0, P);
    add(3, 0, 1, H);
    add(1, 0, 0, P);
    add(1, 0, 0, Z);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].btn);
      chk($sformatf("vec%0d", i), {held, press, long_p, rep}, vecs[i].exp);
    end

    // Reset asserted in the very cycle o_long is high must clear everything.
    step(1'b0, 1'b1);
    chk("rp_e0", {held, press, long_p, rep}, H);
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 20) begin
      step(1'b0, 1'b1);
      edges++;
      if (long_p) seen = 1'b1;
    end
    n_checks++;
    if (!seen || edges != 10) begin
      n_errors++;
      $display("FAIL rp_long_edge: got seen=%0d after %0d edges expected seen=1 after 10", seen, edges);
    end
    step(1'b1, 1'b1);
    chk("rp_reset", {held, press, long_p, rep}, Z);
    step(1'b0, 1'b0);
    chk("rp_wait", {held, press, long_p, rep}, Z);
    step(1'b0, 1'b1);
    chk("rp_new_e0", {held, press, long_p, rep}, H);
    step(1'b0, 1'b0);
    chk("rp_new_press", {held, press, long_p, rep}, P);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
